// File: rtl/lsu_mem_ctrl.sv
// lsu_mem_ctrl: LSU data-memory controller driving a variable-latency req/ack bus
module lsu_mem_ctrl #(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ld_en,
  input  logic [31:0] rd_addr,
  input  logic        wr_en,
  input  logic [31:0] wr_addr,
  input  logic [31:0] wr_data,
  input  logic [1:0]  size,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic [31:0] ld_data,
  output logic        stall,
  output logic        err
);
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  state_t      state;
  logic [1:0]  off;
  logic [7:0]  cnt;
  logic        op, mis, ok;
  logic [31:0] a, wd;
  logic [3:0]  be;
  // decode the incoming op; a store wins when both enables are high
  always_comb begin
    op  = ld_en | wr_en;
    a   = wr_en ? wr_addr : rd_addr;
    mis = (size == 2'b11) || (size == 2'b01 && a[0]) || (size == 2'b10 && a[1:0] != 2'b00);
    ok  = op && !mis;
    be  = size == 2'b00 ? 4'b0001 << a[1:0] : size == 2'b01 ? 4'b0011 << a[1:0] : 4'b1111;
    wd  = size == 2'b00 ? {4{wr_data[7:0]}} : size == 2'b01 ? {2{wr_data[15:0]}} : wr_data;
  end
  assign stall = state == BUSY || (state == IDLE && ok);
  // request sequencing, timeout abort and load-data capture
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_be    <= '0;
      mem_wdata <= '0;
      ld_data   <= '0;
      err       <= 1'b0;
      off       <= '0;
      cnt       <= '0;
    end else begin
      err <= 1'b0;
      case (state)
        IDLE: if (op) begin
          err <= mis || (ld_en && wr_en);
          if (!mis) begin
            state     <= BUSY;
            mem_req   <= 1'b1;
            mem_we    <= wr_en;
            mem_addr  <= {a[31:2], 2'b00};
            mem_be    <= be;
            mem_wdata <= wd;
            off       <= a[1:0];
            cnt       <= '0;
          end
        end
        BUSY: if (mem_ack) begin
          mem_req <= 1'b0;
          state   <= DONE;
          if (!mem_we) ld_data <= mem_rdata >> {off, 3'b000};
        end else if (cnt == 8'(TIMEOUT - 1)) begin
          mem_req <= 1'b0;
          err     <= 1'b1;
          state   <= DONE;
          if (!mem_we) ld_data <= '0;
        end else begin
          cnt <= cnt + 8'd1;
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule
